// File: rtl/mem2_load_wb_stage.sv
// MEM2 back-end: holds loads until cache data returns, aligns/extends the data,
// selects the writeback value and owns the MEM2->WB pipeline register.
module mem2_load_wb_stage #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MEM2_ALUOut,
  input  logic [DATA_W-1:0] MEM2_PC,
  input  logic [1:0]        MEM2_WbSel,
  input  logic [4:0]        MEM2_Dst,
  input  logic              MEM2_RegWr,
  input  logic [2:0]        MEM2_LoadType,
  input  logic [EXC_W-1:0]  MEM2_ExcType,
  input  logic              dcache_rdata_valid,
  input  logic [DATA_W-1:0] dcache_rdata,
  input  logic              WB_Wr,
  input  logic              WB_Flush,
  output logic              MEM2_LoadStall,
  output logic [DATA_W-1:0] WB_Result,
  output logic [DATA_W-1:0] WB_PC,
  output logic [4:0]        WB_Dst,
  output logic              WB_RegWr,
  output logic [EXC_W-1:0]  WB_ExcType
);

  typedef enum logic [1:0] {IDLE, WAIT, BUF} state_t;

  state_t            state, next_state;
  logic              buf_valid;
  logic              capture;
  logic [DATA_W-1:0] buf_data;
  logic              load_pending;
  logic              data_avail;
  logic              exc_free;
  logic [DATA_W-1:0] word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;

  assign exc_free       = (MEM2_ExcType == '0);
  assign load_pending   = (MEM2_WbSel == 2'b01) & MEM2_RegWr & exc_free;
  assign data_avail     = dcache_rdata_valid | buf_valid;
  assign word           = buf_valid ? buf_data : dcache_rdata;
  assign MEM2_LoadStall = load_pending & ~data_avail;

  always_ff @(posedge clk) begin
    if (!rst || WB_Flush) state <= IDLE;
    else                  state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (load_pending && !dcache_rdata_valid)  next_state = WAIT;
        else if (load_pending && !WB_Wr)          next_state = BUF;
      end
      WAIT: begin
        if (dcache_rdata_valid && WB_Wr)          next_state = IDLE;
        else if (dcache_rdata_valid)              next_state = BUF;
      end
      BUF: begin
        if (WB_Wr)                                next_state = IDLE;
      end
      default:                                    next_state = IDLE;
    endcase
  end

  always_comb begin
    buf_valid = (state == BUF);
    capture   = (state != BUF) && (next_state == BUF);
  end

  // Buffer contents only matter while in BUF, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) buf_data <= dcache_rdata;
  end

  always_comb begin
    unique case (MEM2_ALUOut[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = MEM2_ALUOut[1] ? word[31:16] : word[15:0];
    unique case (MEM2_LoadType)
      3'b001:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b011:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    unique case (MEM2_WbSel)
      2'b01:   result = load_data;
      2'b10:   result = MEM2_PC + DATA_W'(8);
      default: result = MEM2_ALUOut;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || WB_Flush || (WB_Wr && MEM2_LoadStall)) begin
      WB_Result  <= '0;
      WB_PC      <= '0;
      WB_Dst     <= '0;
      WB_RegWr   <= 1'b0;
      WB_ExcType <= '0;
    end else if (WB_Wr) begin
      WB_Result  <= result;
      WB_PC      <= MEM2_PC;
      WB_Dst     <= MEM2_Dst;
      WB_RegWr   <= MEM2_RegWr & exc_free;
      WB_ExcType <= MEM2_ExcType;
    end
  end

endmodule

// File: doc/mem2_load_wb_stage.md
Name: mem2_load_wb_stage

Overview:
Second memory stage back-end: consumes the MEM2 pipeline register outputs and the data cache read response. Holds the load until its data returns, aligns and extends it, and selects the writeback value. It owns the MEM2->WB pipeline register. It also raises the MEM2 stall while a load's data is outstanding, and buffers data that returns while WB is frozen.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
EXC_W, 5, exception code width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
MEM2_ALUOut  in  32  address (loads) or ALU result
MEM2_PC  in  32  instruction PC
MEM2_WbSel  in  2  00 ALUOut, 01 load data, 10 PC+8, 11 ALUOut
MEM2_Dst  in  5  destination register
MEM2_RegWr  in  1  GPR write enable (reduced RegsWrType)
MEM2_LoadType  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others = LW
MEM2_ExcType  in  5  nonzero = excepting instruction
dcache_rdata_valid  in  1  one-cycle read data strobe
dcache_rdata  in  32  raw word from cache/uncached bus
WB_Wr  in  1  WB register write enable from hazard unit
WB_Flush  in  1  WB register flush
MEM2_LoadStall  out  1  combinational stall request to hazard unit
WB_Result  out  32  writeback value
WB_PC  out  32  PC in WB
WB_Dst  out  5  destination in WB
WB_RegWr  out  1  write enable in WB
WB_ExcType  out  5  exception code in WB

Behaviour:
- load_pending = (MEM2_WbSel==01) & MEM2_RegWr & (MEM2_ExcType==0).
- data_avail = dcache_rdata_valid | buf_valid.
- Selected word = buf_valid ? buf_data : dcache_rdata.
- MEM2_LoadStall = load_pending & ~data_avail. This is purely combinational, with no added latency.
- FSM states:
  - IDLE: no outstanding load, buffer empty.
  - WAIT: load pending, data not yet returned.
  - BUF: data captured, waiting for WB_Wr.
- FSM transitions:
  - IDLE -> WAIT: load_pending & ~dcache_rdata_valid.
  - IDLE -> BUF: load_pending & dcache_rdata_valid & ~WB_Wr. The word is captured into buf_data.
  - IDLE stays: load_pending & dcache_rdata_valid & WB_Wr, which is a same-cycle hit.
  - WAIT -> IDLE: dcache_rdata_valid & WB_Wr.
  - WAIT -> BUF: dcache_rdata_valid & ~WB_Wr.
  - BUF -> IDLE: WB_Wr. The buffer is consumed.
- dcache_rdata_valid is ignored in IDLE when no load is pending, and in BUF, because at most one response is outstanding.
- WB_Flush in any state forces IDLE and clears buf_valid. A response arriving in that same cycle is discarded.
- Alignment: a = MEM2_ALUOut[1:0].
  - LB/LBU use byte word[8a+7:8a], sign- or zero-extended.
  - LH/LHU use half word[16*a[1]+15:16*a[1]], sign- or zero-extended. a[0] is ignored; misalignment is already an upstream exception.
  - LW uses the word unchanged.
- Result select: WbSel 00/11 -> ALUOut, 01 -> aligned load, 10 -> MEM2_PC+8 (mod 2^32).
- WB register update, priority rst > WB_Flush > WB_Wr:
  - ~rst or WB_Flush: all WB_* outputs are 0; state is IDLE; buf_valid is 0.
  - WB_Wr & MEM2_LoadStall: a bubble is inserted (all WB_* are 0).
  - WB_Wr & ~MEM2_LoadStall: WB_* are loaded from the MEM2 fields and the selected result.
  - ~WB_Wr: WB_* hold.
- Reset mid-load drops the outstanding load. The upstream cache is reset in the same cycle.
- Excepting instructions (ExcType != 0) never stall and pass to WB with ExcType. WB_RegWr is forced to 0 for them.

Test Plan:
1. Same-cycle hit: LW, ALUOut=0x1000, rdata_valid=1, rdata=0xDEADBEEF, WB_Wr=1 -> stall=0; next cycle WB_Result=0xDEADBEEF, WB_RegWr=1, Dst matches.
2. Miss, 3-cycle wait: LB, addr[1:0]=3, rdata valid on cycle 3 with 0x80112233 -> stall=1 on cycles 0-2 and WB receives bubbles; then WB_Result=0xFFFFFF80.
3. Data during WB freeze: LHU, addr[1:0]=2, valid with 0xBEEF1234 while WB_Wr=0 -> state BUF, stall=0; two cycles later WB_Wr=1 -> WB_Result=0x0000BEEF, buffer cleared.
4. Flush while WAIT: LW pending, WB_Flush=1 with rdata_valid=1 -> WB_* = 0, state IDLE; the following ALU instr (WbSel=00, ALUOut=5) writes WB_Result=5.
5. Non-load ops: WbSel=10, PC=0xBFC00000 -> WB_Result=0xBFC00008. Excepting load (ExcType=4) -> no stall, WB_RegWr=0, WB_ExcType=4.
6. Reset: rst=0 during BUF -> next cycle all outputs 0 and state IDLE; a stray rdata_valid afterwards with no load pending is ignored.
